// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants and types for the two-master SRAM arbiter.
//   NUM_M       number of masters sharing the SRAM
//   MEM_RD_LAT  SRAM read latency in cycles (dout valid the cycle after issue)
//   M0 / M1     master ids as carried in the read tag
//   TAG_STAGES  read-tag pipeline depth: issue stage plus MEM_RD_LAT
//   rd_tag_t    {vld, id} tag that follows a read through the SRAM
package sram_arb_pkg;
    localparam int   NUM_M      = 2;
    localparam int   MEM_RD_LAT = 1;
    localparam logic M0         = 1'b0;
    localparam logic M1         = 1'b1;
    localparam int   TAG_STAGES = MEM_RD_LAT + 1;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);
endpackage

// File: rtl/sram_rr_pick.sv
// Combinational 2-way picker.
//   eligible[1:0]  per-master eligibility (bit 0 = m0)
//   last_winner    id of the most recently granted master
//   prio           1: m0 wins every conflict; 0: round-robin
//   winner         chosen master id (don't care when any=0)
//   any            at least one master eligible
module sram_rr_pick
    import sram_arb_pkg::*;
(
    input  logic [NUM_M-1:0] eligible,
    input  logic             last_winner,
    input  logic             prio,
    output logic             winner,
    output logic             any
);
    always_comb begin
        any    = |eligible;
        winner = M0;
        if (eligible == 2'b11) begin
            // conflict: fixed priority favours m0, otherwise alternate
            winner = prio ? M0 : ~last_winner;
        end else if (eligible[1]) begin
            winner = M1;
        end
    end
endmodule

// File: rtl/sram_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-port SRAM (1-cycle read).
// Serializes m0/m1 accesses onto mem_en/we/addr/din and steers each read
// result back to the master that issued it. All outputs are registered.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata      master X request, held until mX_gnt
//   mX_gnt                    pulse: request presented to the SRAM this cycle
//   mX_rvalid, mX_rdata       pulse + held read data for master X
//   mem_en/we/addr/din        SRAM control/address/write data
//   mem_dout                  SRAM read data, valid the cycle after a read
// Build option: SRAM_ARB_FIXED_PRIO_EN adds input fixed_prio (1 = m0 wins
// every conflict, 0 = round-robin). Without it the arbiter is pure round-robin.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef SRAM_ARB_FIXED_PRIO_EN
    input  logic                 fixed_prio,
`endif
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [DATA_BITS-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [DATA_BITS-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [DATA_BITS-1:0] m1_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    input  logic [DATA_BITS-1:0] mem_dout
);
    logic [NUM_M-1:0]           eligible;
    logic                       win;
    logic                       any;
    logic                       prio;
    logic                       last_winner;
    logic                       win_we;
    logic [ADDR_BITS-1:0]       win_addr;
    logic [DATA_BITS-1:0]       win_wdata;
    rd_tag_t [TAG_STAGES-1:0]   tag_pipe;
    rd_tag_t                    tag_out;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign prio = fixed_prio;
`else
    assign prio = 1'b0;
`endif

    // A master granted this cycle still shows req; mask it so it is not issued twice.
    assign eligible = {m1_req & ~m1_gnt, m0_req & ~m0_gnt};

    sram_rr_pick u_pick (
        .eligible    (eligible),
        .last_winner (last_winner),
        .prio        (prio),
        .winner      (win),
        .any         (any)
    );

    assign win_we    = (win == M1) ? m1_we    : m0_we;
    assign win_addr  = (win == M1) ? m1_addr  : m0_addr;
    assign win_wdata = (win == M1) ? m1_wdata : m0_wdata;

    // Tag aligned with the cycle in which mem_dout is valid.
    assign tag_out = tag_pipe[TAG_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            last_winner <= M1;
            tag_pipe    <= '0;
        end else begin
            m0_gnt <= any && (win == M0);
            m1_gnt <= any && (win == M1);
            mem_en <= any;
            mem_we <= any && win_we;
            // addr/din keep their last value while the SRAM is idle
            if (any) begin
                mem_addr    <= win_addr;
                mem_din     <= win_wdata;
                last_winner <= win;
            end

            tag_pipe[0] <= '{vld: any && !win_we, id: win};
            for (int i = 1; i < TAG_STAGES; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            m0_rvalid <= tag_out.vld && (tag_out.id == M0);
            m1_rvalid <= tag_out.vld && (tag_out.id == M1);
            if (tag_out.vld && (tag_out.id == M0)) m0_rdata <= mem_dout;
            if (tag_out.vld && (tag_out.id == M1)) m1_rdata <= mem_dout;
        end
    end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
`timescale 1ns/1ps
module tb_sram_rr_arbiter;
    localparam int AB = 10;
    localparam int DB = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic fixed_prio = 1'b0;
    logic m0_req = 1'b0, m0_we = 1'b0;
    logic [AB-1:0] m0_addr = '0;
    logic [DB-1:0] m0_wdata = '0;
    logic m1_req = 1'b0, m1_we = 1'b0;
    logic [AB-1:0] m1_addr = '0;
    logic [DB-1:0] m1_wdata = '0;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DB-1:0] m0_rdata, m1_rdata;
    logic mem_en, mem_we;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_din;
    logic [DB-1:0] mem_dout = '0;

    always #5 clk = ~clk;

    sram_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .rstn(rstn),
`ifdef SRAM_ARB_FIXED_PRIO_EN
        .fixed_prio(fixed_prio),
`endif
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // single-port SRAM, registered read
    logic [DB-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- master drivers: ops queued by the test ----------------
    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
    } op_t;
    op_t q_op0[$], q_op1[$];
    int  rd0 = 0, rd1 = 0;
    op_t dop;

    always @(negedge clk) begin
        if (!rstn) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
        end else begin
            if (!m0_req || m0_gnt) begin
                if (rd0 < q_op0.size()) begin
                    dop = q_op0[rd0]; rd0++;
                    m0_req = 1'b1; m0_we = dop.we; m0_addr = dop.addr; m0_wdata = dop.wdata;
                end else m0_req = 1'b0;
            end
            if (!m1_req || m1_gnt) begin
                if (rd1 < q_op1.size()) begin
                    dop = q_op1[rd1]; rd1++;
                    m1_req = 1'b1; m1_we = dop.we; m1_addr = dop.addr; m1_wdata = dop.wdata;
                end else m1_req = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb0[$], sb1[$];
    logic [DB-1:0] ref_mem [1024];
    int gcnt[2] = '{0, 0};
    int rcnt[2] = '{0, 0};
    int last_g[2] = '{-1, -1};
    int last_r[2] = '{-1, -1};
    int mchecks = 0, merrors = 0;
    int checks = 0, errors = 0;

    task automatic mchk(input string n, input logic [63:0] act, input logic [63:0] exp);
        mchecks++;
        if (act !== exp) begin
            merrors++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", n, cyc, act, exp);
        end
    endtask

    task automatic mon_master(input int m, input logic g, input logic rv, input logic we,
                              input logic [AB-1:0] addr, input logic [DB-1:0] wdata,
                              input logic [DB-1:0] rdata);
        exp_t e;
        int   sz;
        if (g) begin
            gcnt[m]++;
            last_g[m] = cyc;
            mchk($sformatf("m%0d_mem_addr", m), 64'(mem_addr), 64'(addr));
            mchk($sformatf("m%0d_mem_we", m), 64'(mem_we), 64'(we));
            if (we) begin
                mchk($sformatf("m%0d_mem_din", m), 64'(mem_din), 64'(wdata));
                ref_mem[addr] = wdata;
            end else begin
                e.data = ref_mem[addr];
                e.cyc  = cyc + 2;
                if (m == 0) sb0.push_back(e); else sb1.push_back(e);
            end
        end
        sz = (m == 0) ? sb0.size() : sb1.size();
        if (rv) begin
            rcnt[m]++;
            last_r[m] = cyc;
            if (sz == 0) begin
                mchecks++; merrors++;
                $display("FAIL m%0d_rvalid_unexpected @cyc %0d: got rvalid=1, want 0", m, cyc);
            end else begin
                e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
                mchk($sformatf("m%0d_sb_rdata", m), 64'(rdata), 64'(e.data));
                mchk($sformatf("m%0d_sb_rv_cyc", m), 64'(cyc), 64'(e.cyc));
            end
        end else if (sz != 0) begin
            e = (m == 0) ? sb0[0] : sb1[0];
            if (e.cyc <= cyc) begin
                mchecks++; merrors++;
                $display("FAIL m%0d_rvalid_missing @cyc %0d: got none, want rvalid at %0d", m, cyc, e.cyc);
                if (m == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            sb0.delete();
            sb1.delete();
        end else begin
            mchk("one_gnt_per_cycle", 64'(m0_gnt & m1_gnt), 64'd0);
            mchk("mem_en_vs_gnt", 64'(mem_en), 64'(m0_gnt | m1_gnt));
            mon_master(0, m0_gnt, m0_rvalid, m0_we, m0_addr, m0_wdata, m0_rdata);
            mon_master(1, m1_gnt, m1_rvalid, m1_we, m1_addr, m1_wdata, m1_rdata);
        end
    end

    // ---------------- test sequence ----------------
    task automatic tchk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", n, cyc, act, exp);
        end
    endtask

    task automatic push_op(input int m, input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d;
        if (m == 0) q_op0.push_back(o); else q_op1.push_back(o);
    endtask

    task automatic chk_all_zero(input string n);
        tchk({n, "_ctl"}, 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 64'd0);
        tchk({n, "_addr"}, 64'(mem_addr), 64'd0);
        tchk({n, "_din"}, 64'(mem_din), 64'd0);
        tchk({n, "_rdata"}, {m1_rdata, m0_rdata}, 64'd0);
    endtask

    typedef struct {
        int            m;
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
        logic [DB-1:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic do_single(input vec_t v, input int idx);
        int c, o, g_b, r_b, o_b;
        o = 1 - v.m;
        @(posedge clk); #2;
        c = cyc; g_b = gcnt[v.m]; r_b = rcnt[v.m]; o_b = gcnt[o] + rcnt[o];
        push_op(v.m, v.we, v.addr, v.wdata);
        repeat (5) @(posedge clk);
        #2;
        tchk($sformatf("v%0d_gnt_cyc", idx), 64'(last_g[v.m]), 64'(c + 1));
        tchk($sformatf("v%0d_gnt_once", idx), 64'(gcnt[v.m] - g_b), 64'd1);
        tchk($sformatf("v%0d_other_idle", idx), 64'(gcnt[o] + rcnt[o] - o_b), 64'd0);
        if (!v.we) begin
            tchk($sformatf("v%0d_rv_cyc", idx), 64'(last_r[v.m]), 64'(c + 3));
            tchk($sformatf("v%0d_rdata", idx), 64'(v.m == 1 ? m1_rdata : m0_rdata), 64'(v.exp));
        end else begin
            tchk($sformatf("v%0d_no_rvalid", idx), 64'(rcnt[v.m] - r_b), 64'd0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
    endtask

    initial begin
        int c, rb;
        vec_t v;
        tbl[0] = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h0};
        tbl[3] = '{1, 1'b0, 10'h3FF, 32'h0,        32'hA5A5A5A5};
        tbl[4] = '{0, 1'b0, 10'h3FF, 32'h0,        32'hA5A5A5A5};
        tbl[5] = '{1, 1'b1, 10'h000, 32'hFFFFFFFF, 32'h0};
        tbl[6] = '{0, 1'b0, 10'h000, 32'h0,        32'hFFFFFFFF};
        tbl[7] = '{0, 1'b1, 10'h005, 32'h00000000, 32'h0};
        tbl[8] = '{1, 1'b0, 10'h005, 32'h0,        32'h00000000};
        tbl[9] = '{1, 1'b0, 10'h000, 32'h0,        32'hFFFFFFFF};

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rstn = 1'b1;

        // single accesses, one at a time
        for (int i = 0; i < 10; i++) do_single(tbl[i], i);

        // simultaneous reads straight out of reset: m0 first, m1 next cycle
        push_op(0, 1'b1, 10'h010, 32'h11111111);
        push_op(1, 1'b1, 10'h020, 32'h22222222);
        repeat (5) @(posedge clk);
        pulse_reset();
        @(posedge clk); #2;
        c = cyc;
        push_op(0, 1'b0, 10'h010, 32'h0);
        push_op(1, 1'b0, 10'h020, 32'h0);
        repeat (6) @(posedge clk);
        #2;
        tchk("t2_m0_gnt_cyc", 64'(last_g[0]), 64'(c + 1));
        tchk("t2_m1_gnt_cyc", 64'(last_g[1]), 64'(c + 2));
        tchk("t2_m0_rv_cyc", 64'(last_r[0]), 64'(c + 3));
        tchk("t2_m1_rv_cyc", 64'(last_r[1]), 64'(c + 4));
        tchk("t2_m0_rdata", 64'(m0_rdata), 64'h11111111);
        tchk("t2_m1_rdata", 64'(m1_rdata), 64'h22222222);

        // both masters hold requests: strict alternation, SRAM busy every cycle
        @(posedge clk); #2;
        push_op(0, 1'b1, 10'h100, 32'hA0000100);
        push_op(0, 1'b0, 10'h100, 32'h0);
        push_op(0, 1'b1, 10'h101, 32'hA0000101);
        push_op(0, 1'b0, 10'h101, 32'h0);
        push_op(1, 1'b1, 10'h200, 32'hB0000200);
        push_op(1, 1'b0, 10'h200, 32'h0);
        push_op(1, 1'b0, 10'h100, 32'h0);
        push_op(1, 1'b1, 10'h201, 32'hB0000201);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            tchk($sformatf("t3_m0_gnt_%0d", i), 64'(m0_gnt), 64'(i % 2 == 0));
            tchk($sformatf("t3_m1_gnt_%0d", i), 64'(m1_gnt), 64'(i % 2 == 1));
            tchk($sformatf("t3_mem_en_%0d", i), 64'(mem_en), 64'd1);
        end
        repeat (4) @(posedge clk);

        // m1 alone with queued writes: one access every other cycle
        @(posedge clk); #2;
        rb = rcnt[1];
        for (int i = 0; i < 4; i++) push_op(1, 1'b1, 10'(10'h300 + i), 32'(32'hC0DE0000 + i));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            tchk($sformatf("t4_m1_gnt_%0d", i), 64'(m1_gnt), 64'(i % 2 == 0));
            tchk($sformatf("t4_mem_we_%0d", i), 64'(mem_we), 64'(i % 2 == 0));
            tchk($sformatf("t4_m0_gnt_%0d", i), 64'(m0_gnt), 64'd0);
        end
        repeat (3) @(posedge clk);
        #2;
        tchk("t4_no_rvalid", 64'(rcnt[1] - rb), 64'd0);

        // reset one cycle after an m1 read grant: read is dropped
        @(posedge clk); #2;
        c = cyc;
        push_op(1, 1'b0, 10'h3FF, 32'h0);
        @(posedge clk); #2;
        tchk("t5_m1_gnt", 64'(m1_gnt), 64'd1);
        rb = rcnt[1];
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(posedge clk); #2;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        tchk("t5_no_m1_rvalid", 64'(rcnt[1] - rb), 64'd0);
        tchk("t5_m1_rdata", 64'(m1_rdata), 64'd0);
        v = '{0, 1'b0, 10'h005, 32'h0, 32'h00000000};
        do_single(v, 50);

`ifdef SRAM_ARB_FIXED_PRIO_EN
        // last winner is m0 here; round-robin would pick m1 on the next conflict
        fixed_prio = 1'b1;
        @(posedge clk); #2;
        c = cyc;
        push_op(0, 1'b1, 10'h040, 32'h40404040);
        push_op(0, 1'b0, 10'h040, 32'h0);
        push_op(1, 1'b1, 10'h041, 32'h41414141);
        push_op(1, 1'b0, 10'h041, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            tchk($sformatf("t6_m0_gnt_%0d", i), 64'(m0_gnt), 64'(i % 2 == 0));
            tchk($sformatf("t6_m1_gnt_%0d", i), 64'(m1_gnt), 64'(i % 2 == 1));
        end
        repeat (4) @(posedge clk);
        fixed_prio = 1'b0;
`endif

        repeat (4) @(posedge clk);
        #2;
        tchk("sb_drained", 64'(sb0.size() + sb1.size()), 64'd0);
        errors = errors + merrors;
        checks = checks + mchecks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
